// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use hazard unit for the RV32I core. Tracks, per architectural
//   register, how many more cycles a pending load result is outstanding and
//   holds the instruction in ID back until every register it reads is ready.
//   Also reports the busy set and a saturating count of stall cycles.
//
// Ports
//   clk          core clock
//   rst_n        synchronous active-low reset
//   inst_ID      instruction currently in ID
//   id_valid     inst_ID is a real instruction (0 = bubble)
//   flush        squash the instruction in ID this cycle
//   hold         whole pipeline frozen externally
//   stall        ID must not issue: a source register awaits a load (comb)
//   issue        ID->EX transfer at this edge (comb)
//   busy_mask    bit r set while register r has a pending load result
//   stall_count  saturating count of cycles with stall=1 and hold=0
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         inst_ID,
  input  logic                id_valid,
  input  logic                flush,
  input  logic                hold,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int             CW      = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0]  LAT_VAL = CW'(LOAD_LAT);

  localparam logic [6:0] OC_R      = 7'b0110011;
  localparam logic [6:0] OC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OC_I_LOAD = 7'b0000011;
  localparam logic [6:0] OC_S      = 7'b0100011;
  localparam logic [6:0] OC_B      = 7'b1100011;
  localparam logic [6:0] OC_U_LUI  = 7'b0110111;
  localparam logic [6:0] OC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OC_JAL    = 7'b1101111;
  localparam logic [6:0] OC_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       writer;
  logic       is_load;
  logic       writes_rd;

  assign opcode = inst_ID[6:0];
  assign rd     = inst_ID[11:7];
  assign rs1    = inst_ID[19:15];
  assign rs2    = inst_ID[24:20];

  // funct3/funct7 play no part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^{inst_ID[31:25], inst_ID[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    writer  = 1'b0;
    is_load = 1'b0;
    case (opcode)
      OC_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        writer  = 1'b1;
      end
      OC_S, OC_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OC_I_ALU, OC_JALR: begin
        use_rs1 = 1'b1;
        writer  = 1'b1;
      end
      OC_I_LOAD: begin
        use_rs1 = 1'b1;
        writer  = 1'b1;
        is_load = 1'b1;
      end
      OC_U_LUI, OC_AUIPC, OC_JAL: begin
        writer  = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
      end
    endcase
  end

  assign writes_rd = writer & (rd != 5'd0);

  // Widen the busy set to the full 5-bit register index space so rs1/rs2
  // can index it directly; registers beyond NUM_REGS are never busy.
  logic [31:0] busy_full;

  for (genvar gi = 0; gi < 32; gi++) begin : g_busy_full
    if (gi < NUM_REGS) begin : g_in
      assign busy_full[gi] = busy_mask[gi];
    end else begin : g_out
      assign busy_full[gi] = 1'b0;
    end
  end

  assign stall = id_valid & ((use_rs1 & busy_full[rs1]) | (use_rs2 & busy_full[rs2]));
  assign issue = id_valid & ~stall & ~flush & ~hold;

  // One down-counter per register. x0 has no storage at all.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    if (gi == 0) begin : g_x0
      assign busy_mask[gi] = 1'b0;
    end else begin : g_cnt
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end
        // A newly issued writer of this register overrides the countdown:
        // a load restarts the wait, any other writer makes the value
        // forwardable immediately (younger result wins).
        if (issue && writes_rd && (rd == 5'(gi))) begin
          cnt_next = is_load ? LAT_VAL : '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (!hold) begin
          cnt_reg <= cnt_next;
        end
      end

      assign busy_mask[gi] = (cnt_reg != '0);
    end
  end

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && !(&stall_cnt_reg)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (!hold) begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: three instances (load latency 1, 3, and
// 3 with a 2-bit stall counter) share one input stream. A reference model
// that records, per register, the cycle number at which a pending load
// becomes usable predicts every output each cycle.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_ID = 32'd0;
  logic        id_valid = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;

  logic [2:0]  stall_v;
  logic [2:0]  issue_v;
  logic [31:0] busy0, busy1, busy2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_ID), .id_valid(id_valid),
    .flush(flush), .hold(hold), .stall(stall_v[0]), .issue(issue_v[0]),
    .busy_mask(busy0), .stall_count(cnt0));

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(3), .CNT_W(16)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_ID), .id_valid(id_valid),
    .flush(flush), .hold(hold), .stall(stall_v[1]), .issue(issue_v[1]),
    .busy_mask(busy1), .stall_count(cnt1));

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_ID), .id_valid(id_valid),
    .flush(flush), .hold(hold), .stall(stall_v[2]), .issue(issue_v[2]),
    .busy_mask(busy2), .stall_count(cnt2));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_auipc(input logic [4:0] rd);
    return {20'h00001, rd, 7'b0010111};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] imm);
    return {7'd0, rs2, rs1, 3'b010, imm, 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  // ---------------- reference model ----------------
  // ready[k][r]: value of 'tick' from which register r is no longer busy.
  // tick counts un-held clock edges.
  int ready [3][32];
  int tick = 0;
  int scnt [3] = '{0, 0, 0};
  int lat  [3] = '{1, 3, 3};
  int smax [3] = '{65535, 65535, 3};

  bit obs_stall [3];
  bit obs_issue [3];

  function automatic void model_decode(input logic [31:0] inst,
                                       output bit u1, output bit u2,
                                       output bit wr, output bit ld);
    logic [6:0] op;
    op = inst[6:0];
    u1 = op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011, 7'b1100111};
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    wr = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                     7'b0010111, 7'b1101111, 7'b1100111}) && (inst[11:7] != 5'd0);
    ld = (op == 7'b0000011);
  endfunction

  int cyc = 0;

  // Drive one cycle of inputs, compare all outputs of all three instances
  // against the model, then advance the model across the coming edge.
  task automatic step(input logic [31:0] inst, input bit v, input bit fl,
                      input bit hd, input bit rn);
    bit u1, u2, wr, ld;
    bit es [3];
    bit ei [3];
    logic [31:0] ebusy, obusy, ocnt;
    logic [4:0] rd, rs1, rs2;
    @(negedge clk);
    inst_ID  = inst;
    id_valid = v;
    flush    = fl;
    hold     = hd;
    rst_n    = rn;
    #1;
    model_decode(inst, u1, u2, wr, ld);
    rd  = inst[11:7];
    rs1 = inst[19:15];
    rs2 = inst[24:20];
    for (int k = 0; k < 3; k++) begin
      ebusy = '0;
      for (int r = 1; r < 32; r++) begin
        if (tick < ready[k][r]) ebusy[r] = 1'b1;
      end
      es[k] = v && ((u1 && ebusy[rs1]) || (u2 && ebusy[rs2]));
      ei[k] = v && !es[k] && !fl && !hd;
      obusy = (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
      ocnt  = (k == 0) ? {16'd0, cnt0} : (k == 1) ? {16'd0, cnt1} : {30'd0, cnt2};
      check_val($sformatf("c%0d_stall%0d", cyc, k), {31'd0, stall_v[k]}, {31'd0, es[k]});
      check_val($sformatf("c%0d_issue%0d", cyc, k), {31'd0, issue_v[k]}, {31'd0, ei[k]});
      check_val($sformatf("c%0d_busy%0d", cyc, k), obusy, ebusy);
      check_val($sformatf("c%0d_cnt%0d", cyc, k), ocnt, 32'(scnt[k]));
      obs_stall[k] = stall_v[k];
      obs_issue[k] = issue_v[k];
    end
    $display("cyc %0d inst=%h v=%b fl=%b hd=%b rn=%b stall=%b issue=%b busy1=%h cnt=%0d/%0d/%0d",
             cyc, inst, v, fl, hd, rn, stall_v, issue_v, busy1, cnt0, cnt1, cnt2);
    cyc++;
    if (!rn) begin
      for (int k = 0; k < 3; k++) begin
        scnt[k] = 0;
        for (int r = 0; r < 32; r++) ready[k][r] = 0;
      end
    end else if (!hd) begin
      for (int k = 0; k < 3; k++) begin
        if (es[k] && scnt[k] < smax[k]) scnt[k]++;
        if (ei[k] && wr) ready[k][rd] = ld ? (tick + 1 + lat[k]) : 0;
      end
      tick++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s1, s3, base;
    logic [31:0] ri;
    logic [4:0]  a, b, c;

    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 32; r++) ready[k][r] = 0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, nothing busy after release.
    step(enc_addi(5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("rst_busy", busy1, 32'd0);
    check_val("rst_cnt", {16'd0, cnt1}, 32'd0);
    check_val("rst_stall", {31'd0, obs_stall[1]}, 32'd0);

    // Load-use: lw x5 then addi x2,x5,0 waiting in ID.
    step(enc_lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    s1 = 0; s3 = 0;
    for (int i = 0; i < 5; i++) begin
      step(enc_addi(5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
      s1 += int'(obs_stall[0]);
      s3 += int'(obs_stall[1]);
    end
    check_val("lu_stall_l1", 32'(s1), 32'd1);
    check_val("lu_stall_l3", 32'(s3), 32'd3);
    check_val("lu_cnt_l1", {16'd0, cnt0}, 32'd1);

    // rs2 dependency with a hold in the second stall cycle.
    idle(4);
    base = int'(cnt1);
    step(enc_lw(5'd6, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    s3 = 0;
    for (int i = 0; i < 6; i++) begin
      step(enc_add(5'd3, 5'd0, 5'd6), 1'b1, 1'b0, (i == 1), 1'b1);
      s3 += int'(obs_stall[1]);
    end
    check_val("hold_stall_cycles", 32'(s3), 32'd4);
    check_val("hold_cnt_delta", 32'(int'(cnt1) - base), 32'd3);

    // Independent consumers after lw x7.
    idle(4);
    step(enc_lw(5'd7, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(enc_lui(5'd10), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("indep_lui", {31'd0, obs_stall[1]}, 32'd0);
    step(enc_addi(5'd2, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("indep_addi", {31'd0, obs_stall[1]}, 32'd0);
    idle(4);
    step(enc_lw(5'd0, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(enc_addi(5'd2, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("lw_x0_stall", {31'd0, obs_stall[1]}, 32'd0);
    check_val("lw_x0_busy", busy1, 32'd0);

    // Flushed load leaves no trace.
    idle(4);
    step(enc_lw(5'd5, 5'd1), 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("flush_issue", {31'd0, obs_issue[1]}, 32'd0);
    step(enc_addi(5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("flush_stall", {31'd0, obs_stall[1]}, 32'd0);
    check_val("flush_busy", busy1, 32'd0);

    // WAW: ALU write right behind a load clears the pending entry.
    step(enc_lw(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(enc_addi(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("waw_issue", {31'd0, obs_issue[1]}, 32'd1);
    step(enc_add(5'd9, 5'd8, 5'd8), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("waw_stall", {31'd0, obs_stall[1]}, 32'd0);

    // Reset in the middle of a stall.
    idle(4);
    step(enc_lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(enc_addi(5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("mid_stall_before", {31'd0, obs_stall[1]}, 32'd1);
    step(enc_addi(5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0);
    step(enc_addi(5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("mid_rst_stall", {31'd0, obs_stall[1]}, 32'd0);
    check_val("mid_rst_busy", busy1, 32'd0);
    check_val("mid_rst_cnt", {16'd0, cnt1}, 32'd0);

    // Saturation of the 2-bit counter: six stall cycles.
    for (int rep = 0; rep < 2; rep++) begin
      step(enc_lw(5'd6, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(enc_add(5'd3, 5'd0, 5'd6), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    idle(1);
    check_val("sat_cnt2", {30'd0, cnt2}, 32'd3);
    check_val("sat_cnt_l3", {16'd0, cnt1}, 32'd6);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      c = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1: ri = enc_lw(a, b);
        2:    ri = enc_addi(a, b);
        3:    ri = enc_add(a, b, c);
        4:    ri = enc_lui(a);
        5:    ri = enc_sw(b, c, 5'($urandom_range(0, 31)));
        6:    ri = enc_beq(b, c);
        7:    ri = enc_jal(a, 20'($urandom));
        8:    ri = enc_jalr(a, b);
        default: ri = ($urandom_range(0, 1) == 0) ? enc_auipc(a)
                                                  : {25'($urandom), 7'b1111111};
      endcase
      step(ri, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 49) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
